// File: rtl/ma_pipeline_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 access codes, write-back
// select encodings, FSM state encoding and the access-legality helpers.
package ma_pipeline_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ma_state_t;

    // Stores only have signed encodings; unsigned sizes exist for loads alone.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store);
        if (store)
            return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        return ((f3[1:0] == 2'b01) && offset[0]) || ((f3[1:0] == 2'b10) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/ma_pipeline_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the memory (slave).
interface ma_pipeline_stage_if;
    // Handshake: the master raises dmem_req with we/addr/wdata/wstrb and holds all of them
    // stable until a cycle where dmem_ready = 1; that cycle completes the access and, for
    // reads, dmem_rdata is valid only in that cycle. The master may only drop an unanswered
    // request on timeout or reset.
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/ma_pipeline_stage_load_align.sv
// Load data alignment: picks the addressed byte/half of a read word and sign- or
// zero-extends it according to funct3.
module ma_load_align
    import ma_pipeline_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    value = {{16{half_sel[15]}}, half_sel};
            F3_BU:   value = {24'h000000, byte_sel};
            F3_HU:   value = {16'h0000, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/ma_pipeline_stage.sv
// Memory-access pipeline stage: issues loads/stores on the data bus, stalls the front of
// the pipe while the bus is busy, and registers the write-back result into MA/WB.
module ma_pipeline_stage
    import ma_pipeline_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            RegWEn_in,
    input  logic            MemRW_in,
    input  logic [1:0]      WBSel_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] ALU_Result_in,
    input  logic [XLEN-1:0] DataB_in,
    input  logic [XLEN-1:0] pcPlus4_in,
    input  logic [4:0]      AddrD_in,
    ma_pipeline_stage_if.master bus,
    output logic            stall_out,
    output logic            mem_err_out,
    output logic            RegWEn_out,
    output logic [4:0]      AddrD_out,
    output logic [XLEN-1:0] WB_Result_out,
    output ma_state_t       fsm_state
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    ma_state_t     state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          mem_op, is_store, bad_op, legal_mem, timeout;
    logic          req, stall, bubble;
    logic [1:0]    offset;
    logic [31:0]   load_data, wb_value, wdata;
    logic [3:0]    wstrb;

    assign offset    = ALU_Result_in[1:0];
    assign fsm_state = state;

    always_comb begin
        is_store  = MemRW_in;
        mem_op    = MemRW_in | (RegWEn_in & (WBSel_in == WB_MEM));
        bad_op    = mem_op & (~f3_legal(funct3_in, is_store) | f3_misaligned(funct3_in, offset));
        legal_mem = mem_op & ~bad_op;
        timeout   = (state == ST_WAIT) && (MAX_WAIT != 0) && (wait_cnt == CW'(MAX_WAIT));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // WAIT also exits if the held instruction stops being a legal access.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (legal_mem && !bus.dmem_ready) state_next = ST_WAIT;
            ST_WAIT: if (timeout || bus.dmem_ready || !legal_mem) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request and stall are gated by reset so an in-flight access drops at once.
    always_comb begin
        req   = reset_n & legal_mem & ~timeout;
        stall = req & ~bus.dmem_ready;
        case (funct3_in[1:0])
            2'b00: begin
                wdata = {4{DataB_in[7:0]}};
                wstrb = 4'b0001 << offset;
            end
            2'b01: begin
                wdata = {2{DataB_in[15:0]}};
                wstrb = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = DataB_in;
                wstrb = 4'b1111;
            end
        endcase
        bus.dmem_req   = req;
        bus.dmem_we    = req & is_store;
        bus.dmem_addr  = {ALU_Result_in[31:2], 2'b00};
        bus.dmem_wdata = wdata;
        bus.dmem_wstrb = (req & is_store) ? wstrb : 4'b0000;
        stall_out      = stall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (state == ST_WAIT && state_next == ST_WAIT)
            wait_cnt <= wait_cnt + CW'(1);
        else
            wait_cnt <= '0;
    end

    ma_load_align u_load_align (
        .rdata  (bus.dmem_rdata),
        .offset (offset),
        .funct3 (funct3_in),
        .value  (load_data)
    );

    always_comb begin
        case (WBSel_in)
            WB_MEM:  wb_value = load_data;
            WB_PC4:  wb_value = pcPlus4_in;
            default: wb_value = ALU_Result_in;
        endcase
    end

    assign bubble = stall | bad_op | timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_err_out   <= 1'b0;
            RegWEn_out    <= 1'b0;
            AddrD_out     <= 5'd0;
            WB_Result_out <= '0;
        end else begin
            mem_err_out <= bad_op | timeout;
            if (bubble) begin
                RegWEn_out    <= 1'b0;
                AddrD_out     <= 5'd0;
                WB_Result_out <= '0;
            end else begin
                RegWEn_out    <= RegWEn_in & ~MemRW_in & (AddrD_in != 5'd0);
                AddrD_out     <= AddrD_in;
                WB_Result_out <= wb_value;
            end
        end
    end

endmodule

// File: tb/tb_ma_pipeline_stage.sv
// Self-checking bench for ma_pipeline_stage: directed scenarios plus randomized
// operations scored against a behavioural model of the stage.
module tb_ma_pipeline_stage;
    import ma_pipeline_stage_pkg::*;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RegWEn_in, MemRW_in;
    logic [1:0]  WBSel_in;
    logic [2:0]  funct3_in;
    logic [31:0] ALU_Result_in, DataB_in, pcPlus4_in;
    logic [4:0]  AddrD_in;
    logic        stall_out, mem_err_out, RegWEn_out;
    logic [4:0]  AddrD_out;
    logic [31:0] WB_Result_out;
    ma_state_t   fsm_state;

    ma_pipeline_stage_if bus();

    ma_pipeline_stage #(.XLEN(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .RegWEn_in     (RegWEn_in),
        .MemRW_in      (MemRW_in),
        .WBSel_in      (WBSel_in),
        .funct3_in     (funct3_in),
        .ALU_Result_in (ALU_Result_in),
        .DataB_in      (DataB_in),
        .pcPlus4_in    (pcPlus4_in),
        .AddrD_in      (AddrD_in),
        .bus           (bus.master),
        .stall_out     (stall_out),
        .mem_err_out   (mem_err_out),
        .RegWEn_out    (RegWEn_out),
        .AddrD_out     (AddrD_out),
        .WB_Result_out (WB_Result_out),
        .fsm_state     (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    int          obs_stall;
    logic        obs_req, obs_we, obs_req_end, obs_hung;
    logic [3:0]  obs_wstrb;
    logic [31:0] obs_wdata, obs_addr, obs_wb;
    logic        obs_regwen, obs_err, obs_err2;
    logic [4:0]  obs_rd;

    // driver tasks
    task automatic drive_nop();
        RegWEn_in      = 1'b0;
        MemRW_in       = 1'b0;
        WBSel_in       = WB_ALU;
        funct3_in      = 3'b000;
        ALU_Result_in  = 32'h0;
        DataB_in       = 32'h0;
        pcPlus4_in     = 32'h0;
        AddrD_in       = 5'd0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
    endtask

    // Holds one instruction until the stage releases it; the bus answers after `delay` cycles.
    task automatic do_op(input logic i_regwen, input logic i_memrw, input logic [1:0] i_wbsel,
                         input logic [2:0] i_f3, input logic [31:0] i_alu, input logic [31:0] i_datab,
                         input logic [31:0] i_pc4, input logic [4:0] i_rd, input int delay,
                         input logic [31:0] i_rdata);
        int cyc;
        @(negedge clk);
        RegWEn_in = i_regwen; MemRW_in = i_memrw; WBSel_in = i_wbsel; funct3_in = i_f3;
        ALU_Result_in = i_alu; DataB_in = i_datab; pcPlus4_in = i_pc4; AddrD_in = i_rd;
        obs_stall = 0; obs_req = 0; obs_we = 0; obs_wstrb = 4'h0; obs_wdata = 0; obs_addr = 0;
        obs_hung = 0; obs_req_end = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            bus.dmem_ready = (cyc == delay);
            bus.dmem_rdata = (cyc == delay) ? i_rdata : $urandom;
            #1;
            if (bus.dmem_req) begin
                obs_req = 1'b1; obs_we = bus.dmem_we; obs_wstrb = bus.dmem_wstrb;
                obs_wdata = bus.dmem_wdata; obs_addr = bus.dmem_addr;
            end
            obs_req_end = bus.dmem_req;
            if (!stall_out) break;
            obs_stall++;
            @(negedge clk);
        end
        if (cyc == 20) obs_hung = 1'b1;
        @(negedge clk);
        drive_nop();
        obs_regwen = RegWEn_out; obs_rd = AddrD_out; obs_wb = WB_Result_out; obs_err = mem_err_out;
        @(negedge clk);
        obs_err2 = mem_err_out;
    endtask

    // reference model helpers
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [31:0] sh;
        sh = rdata >> (8 * off);
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd4:    return sh & 32'hFF;
            3'd5:    return sh & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        drive_nop();
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", bus.dmem_req); else n_pass++;
        n_total++; if (stall_out !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_out); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_total++; if (RegWEn_out !== 1'b0) $display("FAIL reset_regwen: got %b expected 0", RegWEn_out); else n_pass++;
        n_total++; if (WB_Result_out !== 32'h0) $display("FAIL reset_wb: got %h expected 0", WB_Result_out); else n_pass++;
        n_total++; if (AddrD_out !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", AddrD_out); else n_pass++;
        n_total++; if (mem_err_out !== 1'b0) $display("FAIL reset_err: got %b expected 0", mem_err_out); else n_pass++;
        n_total++; if (fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected IDLE", fsm_state); else n_pass++;
    endtask

    task automatic test_alu();
        do_op(1'b1, 1'b0, 2'b01, 3'b000, 32'h1234, 32'h0, 32'h8, 5'd5, 0, 32'h0);
        n_total++; if (obs_wb !== 32'h1234) $display("FAIL alu_wb: got %h expected 1234", obs_wb); else n_pass++;
        n_total++; if (obs_regwen !== 1'b1) $display("FAIL alu_regwen: got %b expected 1", obs_regwen); else n_pass++;
        n_total++; if (obs_rd !== 5'd5) $display("FAIL alu_rd: got %0d expected 5", obs_rd); else n_pass++;
        n_total++; if (obs_req !== 1'b0) $display("FAIL alu_req: got %b expected 0", obs_req); else n_pass++;
        n_total++; if (obs_stall !== 0) $display("FAIL alu_stall: got %0d expected 0", obs_stall); else n_pass++;
    endtask

    task automatic test_lb_zero_wait();
        do_op(1'b1, 1'b0, 2'b00, 3'b000, 32'h103, 32'h0, 32'h0, 5'd3, 0, 32'h8000_0000);
        n_total++; if (obs_wb !== 32'hFFFF_FF80) $display("FAIL lb_wb: got %h expected ffffff80", obs_wb); else n_pass++;
        n_total++; if (obs_stall !== 0) $display("FAIL lb_stall: got %0d expected 0", obs_stall); else n_pass++;
        n_total++; if (obs_addr !== 32'h100) $display("FAIL lb_addr: got %h expected 100", obs_addr); else n_pass++;
        n_total++; if (obs_regwen !== 1'b1) $display("FAIL lb_regwen: got %b expected 1", obs_regwen); else n_pass++;
    endtask

    task automatic test_sh_wait();
        do_op(1'b0, 1'b1, 2'b01, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 5'd0, 3, 32'h0);
        n_total++; if (obs_wstrb !== 4'b1100) $display("FAIL sh_wstrb: got %b expected 1100", obs_wstrb); else n_pass++;
        n_total++; if (obs_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h expected abcdabcd", obs_wdata); else n_pass++;
        n_total++; if (obs_we !== 1'b1) $display("FAIL sh_we: got %b expected 1", obs_we); else n_pass++;
        n_total++; if (obs_stall !== 3) $display("FAIL sh_stall: got %0d expected 3", obs_stall); else n_pass++;
        n_total++; if (obs_regwen !== 1'b0) $display("FAIL sh_regwen: got %b expected 0", obs_regwen); else n_pass++;
        n_total++; if (obs_err !== 1'b0) $display("FAIL sh_err: got %b expected 0", obs_err); else n_pass++;
    endtask

    task automatic test_misaligned();
        do_op(1'b1, 1'b0, 2'b00, 3'b010, 32'h101, 32'h0, 32'h0, 5'd4, 0, 32'h1111_1111);
        n_total++; if (obs_req !== 1'b0) $display("FAIL mis_req: got %b expected 0", obs_req); else n_pass++;
        n_total++; if (obs_err !== 1'b1) $display("FAIL mis_err: got %b expected 1", obs_err); else n_pass++;
        n_total++; if (obs_err2 !== 1'b0) $display("FAIL mis_err_pulse: got %b expected 0", obs_err2); else n_pass++;
        n_total++; if (obs_regwen !== 1'b0) $display("FAIL mis_regwen: got %b expected 0", obs_regwen); else n_pass++;
    endtask

    task automatic test_timeout();
        do_op(1'b1, 1'b0, 2'b00, 3'b010, 32'h100, 32'h0, 32'h0, 5'd6, 1000, 32'h0);
        n_total++; if (obs_stall !== MAX_WAIT + 1) $display("FAIL to_stall: got %0d expected %0d", obs_stall, MAX_WAIT + 1); else n_pass++;
        n_total++; if (obs_req_end !== 1'b0) $display("FAIL to_req_drop: got %b expected 0", obs_req_end); else n_pass++;
        n_total++; if (obs_err !== 1'b1) $display("FAIL to_err: got %b expected 1", obs_err); else n_pass++;
        n_total++; if (obs_err2 !== 1'b0) $display("FAIL to_err_pulse: got %b expected 0", obs_err2); else n_pass++;
        n_total++; if (obs_regwen !== 1'b0) $display("FAIL to_regwen: got %b expected 0", obs_regwen); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        RegWEn_in = 1'b1; MemRW_in = 1'b0; WBSel_in = WB_MEM; funct3_in = F3_W;
        ALU_Result_in = 32'h100; AddrD_in = 5'd7; bus.dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_total++; if (fsm_state !== ST_WAIT) $display("FAIL rw_in_wait: got %0d expected WAIT", fsm_state); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL rw_req: got %b expected 0", bus.dmem_req); else n_pass++;
        n_total++; if (stall_out !== 1'b0) $display("FAIL rw_stall: got %b expected 0", stall_out); else n_pass++;
        n_total++; if (fsm_state !== ST_IDLE) $display("FAIL rw_state: got %0d expected IDLE", fsm_state); else n_pass++;
        @(negedge clk);
        drive_nop();
        reset_n = 1'b1;
        do_op(1'b1, 1'b0, 2'b00, 3'b100, 32'h3, 32'h0, 32'h0, 5'd9, 0, 32'hFF00_0000);
        n_total++; if (obs_wb !== 32'h0000_00FF) $display("FAIL rw_lbu_wb: got %h expected 000000ff", obs_wb); else n_pass++;
        n_total++; if (obs_regwen !== 1'b1) $display("FAIL rw_lbu_regwen: got %b expected 1", obs_regwen); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int          kind, delay, size, exp_stall;
            logic        regwen, memrw, mem_op, legal, bad, tmo, exp_err, exp_wen;
            logic [1:0]  wbsel;
            logic [2:0]  f3;
            logic [31:0] alu, datab, pc4, rdata, exp_wb, exp_wdata, got_wb;
            logic [3:0]  exp_wstrb;
            logic [4:0]  rd;
            kind  = $urandom_range(0, 2);
            memrw = (kind == 2);
            regwen = (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            wbsel = (kind == 1) ? WB_MEM : (kind == 0) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            f3    = 3'($urandom_range(0, 7));
            alu   = $urandom; datab = $urandom; pc4 = $urandom; rdata = $urandom;
            rd    = 5'($urandom_range(0, 31));
            delay = $urandom_range(0, MAX_WAIT + 2);

            mem_op = memrw || (regwen && wbsel == WB_MEM);
            legal  = memrw ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            size   = 1 << f3[1:0];
            bad    = mem_op && (!legal || (alu % size) != 0);
            tmo    = mem_op && !bad && delay > MAX_WAIT;
            exp_stall = (!mem_op || bad) ? 0 : tmo ? MAX_WAIT + 1 : delay;
            exp_err   = bad || tmo;
            exp_wen   = regwen && !memrw && rd != 0 && !bad && !tmo;
            exp_wb    = (wbsel == WB_MEM) ? model_load(rdata, alu[1:0], f3) : (wbsel == WB_PC4) ? pc4 : alu;
            exp_wdata = (f3[1:0] == 2'd0) ? (datab & 32'hFF) * 32'h0101_0101 :
                        (f3[1:0] == 2'd1) ? (datab & 32'hFFFF) * 32'h0001_0001 : datab;
            exp_wstrb = (f3[1:0] == 2'd0) ? 4'b0001 << alu[1:0] :
                        (f3[1:0] == 2'd1) ? 4'b0011 << alu[1:0] : 4'b1111;
            if (exp_wen) exp_q.push_back(exp_wb);

            do_op(regwen, memrw, wbsel, f3, alu, datab, pc4, rd, delay, rdata);

            n_total++; if (obs_stall !== exp_stall) $display("FAIL rnd%0d_stall: got %0d expected %0d", i, obs_stall, exp_stall); else n_pass++;
            n_total++; if (obs_req !== (mem_op && !bad)) $display("FAIL rnd%0d_req: got %b expected %b", i, obs_req, mem_op && !bad); else n_pass++;
            n_total++; if (obs_err !== exp_err) $display("FAIL rnd%0d_err: got %b expected %b", i, obs_err, exp_err); else n_pass++;
            n_total++; if (obs_regwen !== exp_wen) $display("FAIL rnd%0d_regwen: got %b expected %b", i, obs_regwen, exp_wen); else n_pass++;
            if (exp_wen) begin
                got_wb = exp_q.pop_front();
                n_total++; if (obs_wb !== got_wb) $display("FAIL rnd%0d_wb: got %h expected %h", i, obs_wb, got_wb); else n_pass++;
                n_total++; if (obs_rd !== rd) $display("FAIL rnd%0d_rd: got %0d expected %0d", i, obs_rd, rd); else n_pass++;
            end
            if (memrw && !bad) begin
                n_total++; if (obs_wstrb !== exp_wstrb) $display("FAIL rnd%0d_wstrb: got %b expected %b", i, obs_wstrb, exp_wstrb); else n_pass++;
                n_total++; if (obs_wdata !== exp_wdata) $display("FAIL rnd%0d_wdata: got %h expected %h", i, obs_wdata, exp_wdata); else n_pass++;
            end
            if (obs_hung) begin
                n_total++;
                $display("FAIL rnd%0d_hang: stall never released within 20 cycles", i);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_lb_zero_wait();
        test_sh_wait();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_random();
        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
